// File: rtl/l1d_mem_responder_if.sv
// L1 D-cache / memory bus bundle: cache-side D_* request and
// response wires plus the memory-side valid/ready request, read and
// write-response channels.
// Ports (signals):
//   D_req/D_addr/D_write/D_in/D_strobe/D_burst : cache request
//   D_out/D_valid/D_wait                       : cache response
//   mem_req_* / mem_addr/write/len/wdata/wstrb : memory request
//   mem_rvalid/rdata/rready                    : read beats
//   mem_bvalid/bready                          : write response
// Modports: slave = responder view, master = cache+memory view.
interface l1d_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              D_req;
  logic [ADDR_W-1:0] D_addr;
  logic              D_write;
  logic [DATA_W-1:0] D_in;
  logic [STRB_W-1:0] D_strobe;
  logic              D_burst;
  logic [DATA_W-1:0] D_out;
  logic              D_valid;
  logic              D_wait;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic              mem_len;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rready;
  logic              mem_bvalid;
  logic              mem_bready;

  modport slave (
    input  D_req, D_addr, D_write,
    input  D_in, D_strobe, D_burst,
    output D_out, D_valid, D_wait,
    output mem_req_valid,
    input  mem_req_ready,
    output mem_addr, mem_write, mem_len,
    output mem_wdata, mem_wstrb,
    input  mem_rvalid, mem_rdata,
    output mem_rready,
    input  mem_bvalid,
    output mem_bready
  );

  modport master (
    output D_req, D_addr, D_write,
    output D_in, D_strobe, D_burst,
    input  D_out, D_valid, D_wait,
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_addr, mem_write, mem_len,
    input  mem_wdata, mem_wstrb,
    output mem_rvalid, mem_rdata,
    input  mem_rready,
    output mem_bvalid,
    input  mem_bready
  );
endinterface

// File: rtl/l1d_mem_responder.sv
// L1 D-cache refill/store responder: turns one cache request into
// one memory transaction and streams read beats back to the cache.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : l1d_mem_responder_if.slave (cache side + memory side)
module l1d_mem_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  l1d_mem_responder_if.slave    bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic              len_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              beat_q;
  logic [DATA_W-1:0] dout_q;

  logic accept_rd;
  logic accept_wr;
  logic beat_fire;
  logic last_beat;

  // An all-ones active-low strobe enables no bytes: drop the store.
  assign accept_rd = bus.D_req & ~bus.D_write;
  assign accept_wr = bus.D_req & bus.D_write
                   & ~(&bus.D_strobe);

  assign beat_fire = (state_q == RD_DATA) & bus.mem_rvalid;
  assign last_beat = beat_fire & (beat_q == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_rd)      state_d = RD_REQ;
        else if (accept_wr) state_d = WR_REQ;
      end
      RD_REQ:
        if (bus.mem_req_ready) state_d = RD_DATA;
      RD_DATA:
        if (last_beat) state_d = IDLE;
      WR_REQ:
        if (bus.mem_req_ready) state_d = WR_RESP;
      WR_RESP:
        if (bus.mem_bvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.mem_rready    = 1'b0;
    bus.mem_bready    = 1'b0;
    bus.D_wait        = 1'b1;
    unique case (state_q)
      IDLE:    bus.D_wait        = 1'b0;
      RD_REQ:  bus.mem_req_valid = 1'b1;
      RD_DATA: bus.mem_rready    = 1'b1;
      WR_REQ:  bus.mem_req_valid = 1'b1;
      WR_RESP: bus.mem_bready    = 1'b1;
      default: bus.D_wait        = 1'b0;
    endcase
  end

  // Beats reach the cache in the cycle they arrive; the register
  // only keeps D_out steady between and after beats.
  assign bus.D_valid = beat_fire;
  assign bus.D_out   = beat_fire ? bus.mem_rdata : dout_q;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_write = write_q;
  assign bus.mem_len   = len_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      len_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state_q == IDLE) begin
      if (accept_rd) begin
        write_q <= 1'b0;
        len_q   <= bus.D_burst;
        wdata_q <= '0;
        wstrb_q <= '0;
        if (bus.D_burst)
          addr_q <= {bus.D_addr[ADDR_W-1:4], 4'h0};
        else
          addr_q <= {bus.D_addr[ADDR_W-1:3], 3'h0};
      end else if (accept_wr) begin
        write_q <= 1'b1;
        len_q   <= 1'b0;
        addr_q  <= {bus.D_addr[ADDR_W-1:3], 3'h0};
        wdata_q <= bus.D_in;
        wstrb_q <= ~bus.D_strobe;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= 1'b0;
      dout_q <= '0;
    end else begin
      if (state_q == RD_REQ && bus.mem_req_ready)
        beat_q <= 1'b0;
      else if (beat_fire)
        beat_q <= beat_q + 1'b1;
      if (beat_fire)
        dout_q <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_l1d_mem_responder.sv
// Directed bench for l1d_mem_responder: refill, single read, store,
// request stall, dropped store and mid-refill reset.
module tb_l1d_mem_responder;
  logic clk;
  logic rst;
  int   errs;
  int   checks;

  l1d_mem_responder_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  l1d_mem_responder #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and checks run at the negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.D_req         = 1'b0;
    bus.D_addr        = '0;
    bus.D_write       = 1'b0;
    bus.D_in          = '0;
    bus.D_strobe      = 8'hFF;
    bus.D_burst       = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    bus.mem_bvalid    = 1'b0;
  endtask

  task automatic issue_read(input logic [31:0] a, input logic b);
    bus.D_req   = 1'b1;
    bus.D_write = 1'b0;
    bus.D_addr  = a;
    bus.D_burst = b;
    tick();
    bus.D_req   = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_wait",   64'(bus.D_wait), 64'd0);
    chk("rst_valid",  64'(bus.D_valid), 64'd0);
    chk("rst_reqv",   64'(bus.mem_req_valid), 64'd0);
    chk("rst_dout",   bus.D_out, 64'd0);
    chk("rst_addr",   64'(bus.mem_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: burst refill
    issue_read(32'h0000_1234, 1'b1);
    chk("t1_reqv", 64'(bus.mem_req_valid), 64'd1);
    chk("t1_addr", 64'(bus.mem_addr), 64'h1230);
    chk("t1_len",  64'(bus.mem_len), 64'd1);
    chk("t1_wr",   64'(bus.mem_write), 64'd0);
    chk("t1_wait", 64'(bus.D_wait), 64'd1);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    chk("t1_reqv_off", 64'(bus.mem_req_valid), 64'd0);
    chk("t1_rready",   64'(bus.mem_rready), 64'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h1111_1111_1111_1111;
    #1;
    chk("t1_v0", 64'(bus.D_valid), 64'd1);
    chk("t1_d0", bus.D_out, 64'h1111_1111_1111_1111);
    tick();
    bus.mem_rdata = 64'h2222_2222_2222_2222;
    #1;
    chk("t1_v1",    64'(bus.D_valid), 64'd1);
    chk("t1_d1",    bus.D_out, 64'h2222_2222_2222_2222);
    chk("t1_wait1", 64'(bus.D_wait), 64'd1);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 64'h3333_3333_3333_3333;
    #1;
    chk("t1_done", 64'(bus.D_wait), 64'd0);
    chk("t1_novld", 64'(bus.D_valid), 64'd0);
    chk("t1_hold", bus.D_out, 64'h2222_2222_2222_2222);

    // 2: single uncacheable read
    issue_read(32'h1000_0004, 1'b0);
    chk("t2_addr", 64'(bus.mem_addr), 64'h1000_0000);
    chk("t2_len",  64'(bus.mem_len), 64'd0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b1;
    bus.mem_rdata     = 64'hA5A5_0000_5A5A_FFFF;
    #1;
    chk("t2_v", 64'(bus.D_valid), 64'd1);
    chk("t2_d", bus.D_out, 64'hA5A5_0000_5A5A_FFFF);
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("t2_idle",   64'(bus.D_wait), 64'd0);
    chk("t2_rready", 64'(bus.mem_rready), 64'd0);

    // 3: partial store
    bus.D_req    = 1'b1;
    bus.D_write  = 1'b1;
    bus.D_addr   = 32'h2000_0104;
    bus.D_in     = {32'hDEADBEEF, 32'h0};
    bus.D_strobe = 8'h0F;
    tick();
    bus.D_req = 1'b0;
    chk("t3_reqv",  64'(bus.mem_req_valid), 64'd1);
    chk("t3_wr",    64'(bus.mem_write), 64'd1);
    chk("t3_addr",  64'(bus.mem_addr), 64'h2000_0100);
    chk("t3_wstrb", 64'(bus.mem_wstrb), 64'hF0);
    chk("t3_wdata", bus.mem_wdata, 64'hDEADBEEF_0000_0000);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    chk("t3_wait",   64'(bus.D_wait), 64'd1);
    chk("t3_bready", 64'(bus.mem_bready), 64'd1);
    chk("t3_novld",  64'(bus.D_valid), 64'd0);
    bus.mem_bvalid = 1'b1;
    tick();
    bus.mem_bvalid = 1'b0;
    chk("t3_done", 64'(bus.D_wait), 64'd0);
    bus.D_write  = 1'b0;
    bus.D_strobe = 8'hFF;

    // 4: request stalled 5 cycles; stray rvalid must be ignored
    issue_read(32'h0000_0048, 1'b1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_reqv", 64'(bus.mem_req_valid), 64'd1);
      chk("t4_addr", 64'(bus.mem_addr), 64'h40);
      chk("t4_len",  64'(bus.mem_len), 64'd1);
      chk("t4_wait", 64'(bus.D_wait), 64'd1);
      chk("t4_novld", 64'(bus.D_valid), 64'd0);
      tick();
    end
    bus.mem_rvalid    = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b1;
    bus.mem_rdata     = 64'h0123_4567_89AB_CDEF;
    tick();
    bus.mem_rdata = 64'hFEDC_BA98_7654_3210;
    #1;
    chk("t4_d1", bus.D_out, 64'hFEDC_BA98_7654_3210);
    tick();
    bus.mem_rvalid = 1'b0;
    chk("t4_done", 64'(bus.D_wait), 64'd0);

    // 5: store with no bytes enabled is dropped
    bus.D_req    = 1'b1;
    bus.D_write  = 1'b1;
    bus.D_addr   = 32'h3000_0008;
    bus.D_strobe = 8'hFF;
    tick();
    bus.D_req = 1'b0;
    #1;
    chk("t5_reqv", 64'(bus.mem_req_valid), 64'd0);
    chk("t5_wait", 64'(bus.D_wait), 64'd0);
    bus.D_write = 1'b0;
    tick();
    chk("t5_wait2", 64'(bus.D_wait), 64'd0);

    // 6: reset after first refill beat
    issue_read(32'h0000_5670, 1'b1);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b1;
    bus.mem_rdata     = 64'h5555_6666_7777_8888;
    tick();
    bus.mem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_wait",   64'(bus.D_wait), 64'd0);
    chk("t6_valid",  64'(bus.D_valid), 64'd0);
    chk("t6_dout",   bus.D_out, 64'd0);
    chk("t6_addr",   64'(bus.mem_addr), 64'd0);
    chk("t6_len",    64'(bus.mem_len), 64'd0);
    chk("t6_rready", 64'(bus.mem_rready), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    issue_read(32'h0000_0010, 1'b0);
    chk("t6_addr2", 64'(bus.mem_addr), 64'h10);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b1;
    bus.mem_rdata     = 64'h0F0F_0F0F_0F0F_0F0F;
    #1;
    chk("t6_v", 64'(bus.D_valid), 64'd1);
    chk("t6_d", bus.D_out, 64'h0F0F_0F0F_0F0F_0F0F);
    tick();
    bus.mem_rvalid = 1'b0;
    chk("t6_done", 64'(bus.D_wait), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
